led_seq: RTL

Parametrised LED pattern sequencer: the next generation of the 8-bit fixed-rate LED runner. It generalises width, adds a programmable step prescaler, run/pause control, four run modes (left, right, bounce, fill bar) and step/wrap status strobes. It sits between the board clock domain and the LED pins, or the LED register of a status bank.

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/led_seq_prescaler.sv | 35 +++
 rtl/led_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Optional BOUNCE support is selected with the LED_SEQ_BOUNCE_EN macro.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ModeLeft   = 2'd0,
    ModeRight  = 2'd1,
    ModeBounce = 2'd2,
    ModeFill   = 2'd3
  } led_mode_e;

  // Pattern shown out of reset: only LED 0 lit.
  localparam logic [63:0] LedResetPat = 64'h1;

  // Width of the position index; never narrower than one bit.
  function automatic int unsigned pos_bits(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Enable-gated step prescaler: emits a one-cycle tick every tick_div+1 enabled cycles.
// Shared by the LED sequencer and other timed status blocks.
module led_seq_prescaler #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] tick_div,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a period shortened below the running count fires at once.
  assign tick_o = en && (cnt_q >= tick_div);

  always_comb begin
    cnt_d = cnt_q;
    if (tick_o) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq.sv
// Parametrised LED pattern sequencer: LEFT, RIGHT, BOUNCE and FILL runs with step/wrap strobes.
// BOUNCE and the direction register exist only when LED_SEQ_BOUNCE_EN is defined.
module led_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] tick_div,
  output logic [WIDTH-1:0] led_o,
  output logic             step_o,
  output logic             wrap_o
);

  localparam int unsigned PW     = pos_bits(WIDTH);
  localparam logic [PW-1:0] PosMax = PW'(WIDTH - 1);
  localparam logic [PW-1:0] PosOne = PW'(1);

  logic            tick;
  logic [PW-1:0]   pos_q, pos_d;
  logic [WIDTH-1:0] led_d;
  logic            wrap_d;
  logic            pos_legal;
  led_mode_e       mode_e;
`ifdef LED_SEQ_BOUNCE_EN
  logic            dir_q, dir_d;
`endif

  led_seq_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick_div (tick_div),
    .tick_o   (tick)
  );

  assign pos_legal = ({1'b0, pos_q} <= {1'b0, PosMax});

  always_comb begin
    mode_e = led_mode_e'(mode);
`ifndef LED_SEQ_BOUNCE_EN
    if (mode_e == ModeBounce) begin
      mode_e = ModeLeft;
    end
`endif
    pos_d  = pos_q;
    wrap_d = 1'b0;
    led_d  = led_o;
`ifdef LED_SEQ_BOUNCE_EN
    dir_d  = dir_q;
`endif
    if (tick) begin
      if (WIDTH == 1) begin
        // Single LED: every step is a full cycle of the sequence.
        pos_d  = '0;
        wrap_d = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
        if (mode_e == ModeRight) begin
          dir_d = 1'b1;
        end else if (mode_e != ModeBounce) begin
          dir_d = 1'b0;
        end
`endif
      end else if (!pos_legal) begin
        pos_d = '0;
      end else begin
        unique case (mode_e)
          ModeRight: begin
            if (pos_q == '0) begin
              pos_d  = PosMax;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - PosOne;
            end
`ifdef LED_SEQ_BOUNCE_EN
            dir_d = 1'b1;
`endif
          end
`ifdef LED_SEQ_BOUNCE_EN
          ModeBounce: begin
            if (!dir_q) begin
              if (pos_q == PosMax) begin
                pos_d = pos_q - PosOne;
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q + PosOne;
              end
            end else begin
              if (pos_q == '0) begin
                pos_d  = pos_q + PosOne;
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q - PosOne;
              end
            end
            // Two LEDs simply alternate; the return to LED 0 marks the wrap.
            if (WIDTH == 2) begin
              wrap_d = (pos_q == PosMax);
            end
          end
`endif
          default: begin
            if (pos_q == PosMax) begin
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + PosOne;
            end
`ifdef LED_SEQ_BOUNCE_EN
            dir_d = 1'b0;
`endif
          end
        endcase
      end
      for (int i = 0; i < WIDTH; i++) begin
        led_d[i] = (mode_e == ModeFill) ? (PW'(i) <= pos_d) : (PW'(i) == pos_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= '0;
      led_o  <= LedResetPat[WIDTH-1:0];
      step_o <= 1'b0;
      wrap_o <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      led_o  <= led_d;
      step_o <= tick;
      wrap_o <= wrap_d;
    end
  end

`ifdef LED_SEQ_BOUNCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

endmodule
